i2c_bus_cond_detector: RTL

Parametrised successor to the single-function stop detector. Synchronises and glitch-filters raw SCL/SDA, then detects START, repeated START and STOP, plus SCL edges, on one clock. Tracks bus-busy state, with a bus-free timeout so a missed STOP cannot leave the bus flagged busy. Sits between the I2C pads and the slave/master protocol FSMs, replacing the separate start/stop detectors.

---
 rtl/i2c_bus_cond_detector.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/i2c_bus_cond_detector.sv
// I2C bus condition detector: synchronises and glitch-filters SCL/SDA, then reports
// START, repeated START, STOP and SCL edges, and tracks bus-busy with an idle timeout.
module i2c_bus_cond_detector #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILT_LEN     = 3,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic scl,
    input  logic sda,
    output logic scl_filt,
    output logic sda_filt,
    output logic start,
    output logic rep_start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall,
    output logic bus_busy,
    output logic idle_timeout
);
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT_LEN - 1);

    // Line index 0 is SCL, index 1 is SDA throughout.
    logic [1:0]                  raw_in;
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][CW-1:0]          cnt_q, cnt_d;
    logic [1:0]                  filt_q, filt_d;
    logic [1:0]                  prev_q, prev_d;
    logic armed_q, armed_d;
    logic busy_q, busy_d;
    logic start_q, start_d, rep_q, rep_d, stop_q, stop_d;
    logic rise_q, rise_d, fall_q, fall_d, idle_q, idle_d;
    logic det, start_cond, stop_cond, start_fire, stop_fire, to_fire;

    assign raw_in = {sda, scl};

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            sync_d[l] = {sync_q[l][SYNC_STAGES-2:0], raw_in[l]};
            cnt_d[l]  = '0;
            filt_d[l] = filt_q[l];
            if (sync_q[l][SYNC_STAGES-1] != filt_q[l]) begin
                if (cnt_q[l] == FILT_LAST) filt_d[l] = sync_q[l][SYNC_STAGES-1];
                else                       cnt_d[l]  = cnt_q[l] + CW'(1);
            end
        end
    end

    // Start/stop need SCL high in both cycles, so an SDA change coincident with an
    // SCL change can only ever show up as an SCL edge.
    assign det        = enable & armed_q;
    assign start_cond = prev_q[1] & ~filt_q[1] & prev_q[0] & filt_q[0];
    assign stop_cond  = ~prev_q[1] & filt_q[1] & prev_q[0] & filt_q[0];
    assign start_fire = det & start_cond;
    assign stop_fire  = det & stop_cond;

    generate
        if (IDLE_TIMEOUT > 0) begin : g_timeout
            localparam int TW = $clog2(IDLE_TIMEOUT + 1);
            localparam logic [TW-1:0] TO_LAST = TW'(IDLE_TIMEOUT - 1);
            logic [TW-1:0] to_cnt_q, to_cnt_d;
            logic          to_hit;

            always_comb begin
                to_cnt_d = '0;
                to_hit   = 1'b0;
                if (enable & busy_q & filt_q[0] & filt_q[1]) begin
                    if (to_cnt_q == TO_LAST) to_hit   = 1'b1;
                    else                     to_cnt_d = to_cnt_q + TW'(1);
                end
            end

            // A STOP landing on the expiry cycle takes precedence.
            assign to_fire = to_hit & ~stop_fire;

            always_ff @(posedge clk) begin
                if (!rst_n) to_cnt_q <= '0;
                else        to_cnt_q <= to_cnt_d;
            end
        end else begin : g_no_timeout
            assign to_fire = 1'b0;
        end
    endgenerate

    always_comb begin
        armed_d = enable & (armed_q | (filt_q[0] & filt_q[1]));
        prev_d  = filt_q;
        start_d = start_fire;
        rep_d   = start_fire & busy_q;
        stop_d  = stop_fire;
        rise_d  = det & ~prev_q[0] & filt_q[0];
        fall_d  = det & prev_q[0] & ~filt_q[0];
        idle_d  = to_fire;
        busy_d  = busy_q;
        if (!enable)                   busy_d = 1'b0;
        else if (start_fire)           busy_d = 1'b1;
        else if (stop_fire | to_fire)  busy_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            rep_q   <= 1'b0;
            stop_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            idle_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            rep_q   <= rep_d;
            stop_q  <= stop_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            idle_q  <= idle_d;
        end
    end

    assign scl_filt     = filt_q[0];
    assign sda_filt     = filt_q[1];
    assign start        = start_q;
    assign rep_start    = rep_q;
    assign stop         = stop_q;
    assign scl_rise     = rise_q;
    assign scl_fall     = fall_q;
    assign bus_busy     = busy_q;
    assign idle_timeout = idle_q;
endmodule
